// File: rtl/conv3x3_param.sv
// -----------------------------------------------------------------------------
// conv3x3_param
//
// Streaming 3x3 convolution over a raster-order pixel stream. Each input beat
// produces one output beat exactly three clocks later. Outputs whose window
// would reach past the top or left edge of the frame are forced to 0.
//
// The coefficient bank is double-buffered. Writes land in a shadow bank. The
// shadow bank becomes active on the start-of-frame beat, so a frame is always
// filtered with a single, consistent kernel.
//
// Optional feature:
//   CONV_ABS_EN  when defined, the magnitude of the sum is taken before the
//                shift and saturation (edge-magnitude mode). When undefined,
//                negative sums saturate to 0.
//
// Ports:
//   iCLK        clock, all state on the rising edge
//   iRST        asynchronous, active-low reset
//   iDATA       input pixel (unsigned, DW bits), raster order
//   iDVAL       input pixel valid, one beat per high cycle
//   iSOF        start of frame, qualified by iDVAL, marks pixel (0,0)
//   iCOEF_WE    coefficient write strobe (shadow bank)
//   iCOEF_ADDR  coefficient index 0..8 row-major, 0 = top-left; 9..15 ignored
//   iCOEF_DATA  coefficient value (signed, CW bits)
//   oDATA       filtered pixel, holds its value while oDVAL is low
//   oDVAL       output valid
//   oSOF        start of frame, aligned with oDVAL
// -----------------------------------------------------------------------------
module conv3x3_param #(
  parameter int DW         = 12,
  parameter int CW         = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int NORM_SHIFT = 0
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [DW-1:0]        iDATA,
  input  logic                 iDVAL,
  input  logic                 iSOF,
  input  logic                 iCOEF_WE,
  input  logic [3:0]           iCOEF_ADDR,
  input  logic signed [CW-1:0] iCOEF_DATA,
  output logic [DW-1:0]        oDATA,
  output logic                 oDVAL,
  output logic                 oSOF
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  // Product of an unsigned DW-bit pixel and a signed CW-bit coefficient.
  localparam int PW    = DW + CW + 1;
  // Nine products summed without overflow.
  localparam int SW    = DW + CW + 4;

  localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [SW-1:0] PIX_MAX  = {{(SW-DW){1'b0}}, {DW{1'b1}}};

  // Sharpening kernel: 9 in the centre, -1 around it.
  function automatic logic signed [CW-1:0] coef_default(input int idx);
    return (idx == 4) ? CW'(9) : CW'(-1);
  endfunction

  function automatic logic signed [PW-1:0] mul_pix(
    input logic [DW-1:0]        pix,
    input logic signed [CW-1:0] coef
  );
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = {{(PW-DW){1'b0}}, pix};
    b = {{(PW-CW){coef[CW-1]}}, coef};
    return a * b;
  endfunction

  function automatic logic [DW-1:0] norm_sat(input logic signed [SW-1:0] sum);
    logic signed [SW-1:0] mag;
    logic signed [SW-1:0] shifted;
`ifdef CONV_ABS_EN
    mag = sum[SW-1] ? -sum : sum;
`else
    mag = sum;
`endif
    shifted = mag >>> NORM_SHIFT;
    if (shifted[SW-1]) begin
      return '0;
    end else if (shifted > PIX_MAX) begin
      return {DW{1'b1}};
    end else begin
      return shifted[DW-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Raster position. On an iSOF beat the position is forced to (0,0), whatever
  // the counters hold. This lets the block resynchronise on a short or long
  // frame.
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;

  always_comb begin
    eff_col = col;
    eff_row = row;
    if (iSOF) begin
      eff_col = '0;
      eff_row = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      col <= '0;
      row <= '0;
    end else if (iDVAL) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
      end else begin
        col <= eff_col + COL_W'(1);
        row <= eff_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. lb1 holds the previous line and lb2 the line before it. The
  // contents are never cleared. After reset or resync, stale entries can only
  // feed rows 0 and 1, and those are border outputs.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [DW-1:0] up1;
  logic [DW-1:0] up2;

  assign up1 = lb1[eff_col];
  assign up2 = lb2[eff_col];

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb1[eff_col] <= iDATA;
      lb2[eff_col] <= up1;
    end
  end

  // Horizontal delays per window row (0 = top):
  //   dly_a holds column c-1, dly_b holds column c-2.
  logic [DW-1:0] colv  [3];
  logic [DW-1:0] dly_a [3];
  logic [DW-1:0] dly_b [3];
  logic [DW-1:0] win   [9];

  always_comb begin
    colv[0] = up2;
    colv[1] = up1;
    colv[2] = iDATA;
    for (int r = 0; r < 3; r++) begin
      win[r*3 + 0] = dly_b[r];
      win[r*3 + 1] = dly_a[r];
      win[r*3 + 2] = colv[r];
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int r = 0; r < 3; r++) begin
        dly_a[r] <= '0;
        dly_b[r] <= '0;
      end
    end else if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        dly_b[r] <= dly_a[r];
        dly_a[r] <= colv[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient banks. A write coincident with the iSOF beat is merged into
  // the copy. This lets software update the kernel on the very first pixel.
  // ---------------------------------------------------------------------------
  logic signed [CW-1:0] coef_sh     [9];
  logic signed [CW-1:0] coef_sh_nxt [9];
  logic signed [CW-1:0] coef_act    [9];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      coef_sh_nxt[i] = coef_sh[i];
      if (iCOEF_WE && (iCOEF_ADDR == 4'(i))) begin
        coef_sh_nxt[i] = iCOEF_DATA;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < 9; i++) begin
        coef_sh[i]  <= coef_default(i);
        coef_act[i] <= coef_default(i);
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        coef_sh[i] <= coef_sh_nxt[i];
        if (iDVAL && iSOF) begin
          coef_act[i] <= coef_sh_nxt[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: capture the 3x3 window and the border flag.
  // ---------------------------------------------------------------------------
  logic          vld_p0;
  logic          sof_p0;
  logic          border_p0;
  logic [DW-1:0] win_p0 [9];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vld_p0    <= 1'b0;
      sof_p0    <= 1'b0;
      border_p0 <= 1'b0;
    end else begin
      vld_p0 <= iDVAL;
      sof_p0 <= iDVAL & iSOF;
      if (iDVAL) begin
        border_p0 <= (eff_col < COL_W'(2)) || (eff_row < ROW_W'(2));
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      for (int i = 0; i < 9; i++) begin
        win_p0[i] <= win[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: nine products against the active bank. The bank was updated on
  // the same edge that loaded p0 for an iSOF beat.
  // ---------------------------------------------------------------------------
  logic                 vld_p1;
  logic                 sof_p1;
  logic                 border_p1;
  logic signed [PW-1:0] prod_p1 [9];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vld_p1    <= 1'b0;
      sof_p1    <= 1'b0;
      border_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      sof_p1 <= vld_p0 & sof_p0;
      if (vld_p0) begin
        border_p1 <= border_p0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (vld_p0) begin
      for (int i = 0; i < 9; i++) begin
        prod_p1[i] <= mul_pix(win_p0[i], coef_act[i]);
      end
    end
  end

  logic signed [SW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 9; i++) begin
      sum_c = sum_c + {{(SW-PW){prod_p1[i][PW-1]}}, prod_p1[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: sum, normalise and saturate, then register. oDATA only
  // loads on valid beats, so it holds between beats.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA <= '0;
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
    end else begin
      oDVAL <= vld_p1;
      oSOF  <= vld_p1 & sof_p1;
      if (vld_p1) begin
        oDATA <= border_p1 ? '0 : norm_sat(sum_c);
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_param.sv
module tb_conv3x3_param;

  localparam int DW         = 12;
  localparam int CW         = 8;
  localparam int IMG_W      = 8;
  localparam int IMG_H      = 6;
  localparam int NORM_SHIFT = 0;
  localparam int PMAX       = (1 << DW) - 1;

  logic                 iCLK       = 1'b0;
  logic                 iRST       = 1'b0;
  logic [DW-1:0]        iDATA      = '0;
  logic                 iDVAL      = 1'b0;
  logic                 iSOF       = 1'b0;
  logic                 iCOEF_WE   = 1'b0;
  logic [3:0]           iCOEF_ADDR = '0;
  logic signed [CW-1:0] iCOEF_DATA = '0;
  logic [DW-1:0]        oDATA;
  logic                 oDVAL;
  logic                 oSOF;

  conv3x3_param #(
    .DW(DW), .CW(CW), .IMG_W(IMG_W), .IMG_H(IMG_H), .NORM_SHIFT(NORM_SHIFT)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA),
    .oDATA(oDATA), .oDVAL(oDVAL), .oSOF(oSOF)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] last_data = '0;

  int img [IMG_H][IMG_W];
  int m_sh [9];
  int m_act [9];
  int m_col = 0;
  int m_row = 0;

  function automatic int coef_def(input int i);
    return (i == 4) ? 9 : -1;
  endfunction

  function automatic int ref_sat(input int s);
    int v;
    v = s;
`ifdef CONV_ABS_EN
    if (v < 0) v = -v;
`endif
    v = v >>> NORM_SHIFT;
    if (v < 0) v = 0;
    if (v > PMAX) v = PMAX;
    return v;
  endfunction

  function automatic int pattern(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (r == 3 && c == 4) ? PMAX : 0;
      2:       return (r == 3 && c == 4) ? 0 : 100;
      default: return (c * 37 + r * r * 101 + 5) % 4096;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_sh[i]  = coef_def(i);
      m_act[i] = coef_def(i);
    end
    m_col = 0;
    m_row = 0;
    sbq.delete();
    last_data = '0;
  endtask

  // One clock of stimulus; a valid beat pushes its expected output.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic sof,
                      input logic we, input logic [3:0] addr, input int cdata);
    exp_t e;
    int   s;
    @(posedge iCLK);
    #1;
    iDVAL      = dv;
    iDATA      = d;
    iSOF       = sof;
    iCOEF_WE   = we;
    iCOEF_ADDR = addr;
    iCOEF_DATA = CW'(cdata);
    if (we && addr <= 4'd8) m_sh[addr] = cdata;
    if (dv) begin
      if (sof) begin
        m_col = 0;
        m_row = 0;
        m_act = m_sh;
      end
      img[m_row][m_col] = int'(d);
      if (m_col < 2 || m_row < 2) begin
        e.data = '0;
      end else begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += img[m_row-2+i][m_col-2+j] * m_act[i*3+j];
        e.data = DW'(ref_sat(s));
      end
      e.sof = sof;
      e.due = cyc + 3;
      sbq.push_back(e);
      if (m_col == IMG_W - 1) begin
        m_col = 0;
        m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  // Idle cycle with junk on the data and SOF lines.
  task automatic idle();
    step(1'b0, DW'($urandom), 1'($urandom), 1'b0, 4'd0, 0);
  endtask

  task automatic do_reset();
    @(posedge iCLK);
    #1;
    iRST     = 1'b0;
    iDVAL    = 1'b0;
    iSOF     = 1'b0;
    iCOEF_WE = 1'b0;
    model_reset();
    #1;
    n_vec++;
    assert (oDATA === '0) else begin
      n_err++; $error("FAIL rst_data observed=%0d expected=0", oDATA);
    end
    n_vec++;
    assert (oDVAL === 1'b0) else begin
      n_err++; $error("FAIL rst_dval observed=%b expected=0", oDVAL);
    end
    n_vec++;
    assert (oSOF === 1'b0) else begin
      n_err++; $error("FAIL rst_sof observed=%b expected=0", oSOF);
    end
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    repeat (4) idle();
  endtask

  // wr_at: beat index before which the kernel (centre=1) is written to shadow
  // rst_at: beat index after which reset is asserted and the frame abandoned
  task automatic frame(input int kind, input int gap_pct, input int wr_at,
                       input int rst_at, input logic sof_wr);
    int idx;
    int px;
    idx = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        px = pattern(kind, r, c);
        for (int g = 0; g < 6; g++) begin
          if ($urandom_range(0, 99) < gap_pct) idle();
        end
        if (idx == wr_at) begin
          for (int a = 0; a < 10; a++) begin
            if (a == 9) step(1'b0, '0, 1'b0, 1'b1, 4'd12, 55);
            else        step(1'b0, '0, 1'b0, 1'b1, 4'(a), (a == 4) ? 1 : 0);
          end
        end
        if (r == 0 && c == 0 && sof_wr)
          step(1'b1, DW'(px), 1'b1, 1'b1, 4'd4, 2);
        else
          step(1'b1, DW'(px), (r == 0 && c == 0), 1'b0, 4'd0, 0);
        if (idx == rst_at) begin
          do_reset();
          return;
        end
        idx++;
      end
    end
  endtask

  // Output monitor: compares valid, data and SOF every cycle against the queue.
  always @(negedge iCLK) begin : mon
    exp_t e;
    logic exp_v;
    if (mon_en) begin
      exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      n_vec++;
      assert (oDVAL === exp_v) else begin
        n_err++; $error("FAIL dval cyc=%0d observed=%b expected=%b", cyc, oDVAL, exp_v);
      end
      if (exp_v) begin
        e = sbq.pop_front();
        n_vec++;
        assert (oDATA === e.data) else begin
          n_err++; $error("FAIL data cyc=%0d observed=%0d expected=%0d", cyc, oDATA, e.data);
        end
        n_vec++;
        assert (oSOF === e.sof) else begin
          n_err++; $error("FAIL sof cyc=%0d observed=%b expected=%b", cyc, oSOF, e.sof);
        end
        last_data = e.data;
      end else begin
        n_vec++;
        assert (oDATA === last_data) else begin
          n_err++; $error("FAIL hold cyc=%0d observed=%0d expected=%0d", cyc, oDATA, last_data);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge iCLK);
    #1;
    n_vec++;
    assert (oDATA === '0) else begin
      n_err++; $error("FAIL init_data observed=%0d expected=0", oDATA);
    end
    n_vec++;
    assert (oDVAL === 1'b0) else begin
      n_err++; $error("FAIL init_dval observed=%b expected=0", oDVAL);
    end
    n_vec++;
    assert (oSOF === 1'b0) else begin
      n_err++; $error("FAIL init_sof observed=%b expected=0", oSOF);
    end
    @(posedge iCLK);
    #1;
    iRST   = 1'b1;
    mon_en = 1'b1;

    frame(0, 0, -1, -1, 1'b0);   // flat 100
    frame(1, 0, -1, -1, 1'b0);   // isolated full-scale pixel
    frame(2, 0, -1, -1, 1'b0);   // dark centre, negative sum
    frame(3, 0, -1, -1, 1'b0);   // ramp, no gaps
    frame(3, 50, -1, -1, 1'b0);  // ramp, random gaps
    frame(3, 0, 20, -1, 1'b0);   // kernel rewritten mid-frame
    frame(3, 20, -1, -1, 1'b0);  // identity-delay kernel now active
    frame(3, 0, -1, -1, 1'b1);   // centre=2 written on the SOF beat
    frame(0, 0, -1, 19, 1'b0);   // reset at pixel (3,2)
    frame(0, 0, -1, -1, 1'b0);   // clean frame after reset

    repeat (8) idle();
    n_vec++;
    assert (sbq.size() == 0) else begin
      n_err++; $error("FAIL drain observed=%0d expected=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_param.md
CONV3X3_PARAM -- requirements
Module: conv3x3_param

Interface
REQ-001 Parameter DW, 12, pixel width in bits (unsigned).
REQ-002 Parameter CW, 8, coefficient width in bits (signed two's complement).
REQ-003 Parameter IMG_W, 640, pixels per line; IMG_H, 480, lines per frame.
REQ-004 Parameter NORM_SHIFT, 0, arithmetic right shift applied to the sum before saturation.
REQ-005 iCLK  input  1  single clock; all state on rising edge.
REQ-006 iRST  input  1  asynchronous, active-low reset.
REQ-007 iDATA  input  DW  pixel, raster order; iDVAL input 1 pixel valid (one beat per high cycle).
REQ-008 iSOF  input  1  start of frame; qualified by iDVAL; marks pixel (0,0).
REQ-009 iCOEF_WE input 1; iCOEF_ADDR input 4 (0..8, row-major, 0=top-left); iCOEF_DATA input CW.
REQ-010 oDATA  output  DW  filtered pixel; oDVAL output 1 valid; oSOF output 1 start of frame, aligned with oDVAL.

Function
REQ-011 Window state (two line buffers of IMG_W entries, 3x2 horizontal delay registers, col/row counters) SHALL advance only on iDVAL beats; idle cycles leave it unchanged.
REQ-012 Col counter SHALL increment per beat, wrap IMG_W-1 -> 0 and increment row; row SHALL wrap IMG_H-1 -> 0.
REQ-013 iSOF with iDVAL SHALL force col=row=0 for that beat, regardless of counter state (resync).
REQ-014 Window for a beat at (c,r) SHALL cover cols c-2..c, rows r-2..r, current pixel bottom-right.
REQ-015 Output SHALL be exactly one per input beat; W*H outputs per frame.
REQ-016 If c<2 or r<2, the output value SHALL be 0 (border); otherwise the computed value.
REQ-017 oDVAL SHALL assert exactly 3 iCLK cycles after the corresponding iDVAL beat, irrespective of gaps; oSOF SHALL mark the output of the iSOF beat.
REQ-018 Sum SHALL be the signed sum of nine products pixel*coef, DW+CW+4 bits wide, no overflow.
REQ-019 Result = sum >>> NORM_SHIFT, then saturated to [0, 2^DW-1].
REQ-020 Coefficient writes (iCOEF_WE, addr<=8) SHALL go to a shadow bank; addr 9..15 SHALL be ignored.
REQ-021 Shadow bank SHALL copy to the active bank on an iSOF beat, before that pixel's product is computed; mid-frame writes SHALL NOT affect the current frame.
REQ-022 A coefficient write coincident with an iSOF beat SHALL be included in the copy.
REQ-023 oDATA SHALL hold its last value when oDVAL is low.

Reset
REQ-024 iRST low SHALL immediately clear oDATA, oDVAL, oSOF, counters, delay registers and pipeline valids to 0.
REQ-025 Both coefficient banks SHALL reset to {-1,-1,-1,-1,9,-1,-1,-1,-1}.
REQ-026 Line-buffer contents need not reset; counters at 0 ensure stale data only ever reaches border outputs.
REQ-027 Reset mid-frame SHALL drop in-flight outputs; no oDVAL in the 3 cycles after release without new beats.

Configuration
REQ-028 Macro CONV_ABS_EN defined: the absolute value of the sum SHALL be taken before shift and saturation (edge-magnitude mode).
REQ-029 CONV_ABS_EN undefined: negative sums SHALL saturate to 0; no abs logic present.

Verification (bench IMG_W=8, IMG_H=6, DW=12, CW=8, NORM_SHIFT=0)
REQ-030 Flat frame of 100, default kernel -> 48 outputs; c<2 or r<2 give 0, interior gives 100; oDVAL 3 cycles after each beat.
REQ-031 Isolated 4095 with 0 elsewhere -> 4095 (saturated) where it is window centre, 0 where it is a neighbour (without CONV_ABS_EN), 4095 with it.
REQ-032 Centre 0, neighbours 100 -> sum -800: 0 without CONV_ABS_EN, 800 with it.
REQ-033 Random iDVAL gaps (~50% duty) on a ramp image -> output sequence identical to gap-free run.
REQ-034 Write coef 4 = 1, others 0, mid-frame -> current frame unchanged; next frame output equals input delayed one line and one pixel (interior).
REQ-035 Assert iRST at pixel (3,2) then restart with iSOF -> all outputs cleared at once; new frame matches REQ-030.
